output_requantizer: RTL and testbench

Downstream stage of the convolution datapath. Consumes the 32-bit MAC results with their (x, y, ch) coordinates, applies a rounding arithmetic right shift, saturates to the 16-bit output format and optionally clamps negatives (ReLU). It buffers the results in a small FIFO and presents them on a valid/ready output stream, with backpressure toward the controller.

---
 rtl/output_requantizer.sv | 210 +++++++++++++++++++++
 tb/tb_output_requantizer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/output_requantizer.sv
`default_nettype none
// ============================================================================
// Module   : output_requantizer
// Purpose  : Requantizes 32-bit MAC results to 16-bit outputs. Applies a
//            rounding arithmetic right shift and saturation, with optional
//            ReLU. Results pass through a compute register and a small FIFO
//            onto a valid/ready stream. The upstream side uses credit-based
//            backpressure.
// Options  : OUTPUT_RELU_EN - when defined, negative results clamp to zero
// Revision : 1.0 - initial release
// ============================================================================
module output_requantizer #(
    parameter int ACCUMULATION_WIDTH = 32,
    parameter int IO_DATA_WIDTH      = 16,
    parameter int FIFO_DEPTH         = 4,
    parameter int FEATURE_MAP_WIDTH  = 1024,
    parameter int FEATURE_MAP_HEIGHT = 1024,
    parameter int OUTPUT_NB_CHANNELS = 64,
    localparam int X_W  = $clog2(FEATURE_MAP_WIDTH),
    localparam int Y_W  = $clog2(FEATURE_MAP_HEIGHT),
    localparam int CH_W = $clog2(OUTPUT_NB_CHANNELS)
) (
    input  logic                          clk,
    input  logic                          arst_in,
    input  logic                          clear,
    input  logic [4:0]                    shift,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ACCUMULATION_WIDTH-1:0] in_data,
    input  logic [X_W-1:0]                in_x,
    input  logic [Y_W-1:0]                in_y,
    input  logic [CH_W-1:0]               in_ch,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [IO_DATA_WIDTH-1:0]      out_data,
    output logic [X_W-1:0]                out_x,
    output logic [Y_W-1:0]                out_y,
    output logic [CH_W-1:0]               out_ch,
    output logic                          sat_flag,
    output logic                          overflow_err
);

    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int EXT_W   = ACCUMULATION_WIDTH + 1;
    localparam int ENTRY_W = IO_DATA_WIDTH + X_W + Y_W + CH_W;

    // Saturation bounds expressed in the widened arithmetic domain
    localparam logic signed [EXT_W-1:0] C_SAT_MAX =
        {{(EXT_W-IO_DATA_WIDTH+1){1'b0}}, {(IO_DATA_WIDTH-1){1'b1}}};
    localparam logic signed [EXT_W-1:0] C_SAT_MIN =
        {{(EXT_W-IO_DATA_WIDTH+1){1'b1}}, {(IO_DATA_WIDTH-1){1'b0}}};
    localparam logic [IO_DATA_WIDTH-1:0] C_OUT_MAX = {1'b0, {(IO_DATA_WIDTH-1){1'b1}}};
    localparam logic [IO_DATA_WIDTH-1:0] C_OUT_MIN = {1'b1, {(IO_DATA_WIDTH-1){1'b0}}};
    localparam logic [CNT_W:0]           C_DEPTH   = FIFO_DEPTH[CNT_W:0];

    // Arithmetic path
    logic signed [EXT_W-1:0]    w_ext;
    logic signed [EXT_W-1:0]    w_rc;
    logic signed [EXT_W-1:0]    w_sum;
    logic signed [EXT_W-1:0]    w_shr;
    logic [IO_DATA_WIDTH-1:0]   w_sat_val;
    logic [IO_DATA_WIDTH-1:0]   w_res;
    logic                       w_is_sat;

    // Stage 1 compute register
    logic                       r_s1_valid;
    logic [IO_DATA_WIDTH-1:0]   r_s1_data;
    logic [X_W-1:0]             r_s1_x;
    logic [Y_W-1:0]             r_s1_y;
    logic [CH_W-1:0]            r_s1_ch;

    // FIFO state
    logic [ENTRY_W-1:0]         r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]           r_wr_ptr;
    logic [PTR_W-1:0]           r_rd_ptr;
    logic [CNT_W-1:0]           r_count;
    logic [ENTRY_W-1:0]         w_head;

    // Handshake
    logic [CNT_W:0]             w_occ;
    logic                       w_accept;
    logic                       w_push;
    logic                       w_pop;
    logic                       w_not_empty;

    // Sticky flags
    logic                       r_sat_flag;
    logic                       r_overflow;

    // Rounding shift in one extra bit so the rounding constant cannot wrap,
    // then saturation to the output range and optional ReLU clamp.
    always_comb begin
        w_ext     = {in_data[ACCUMULATION_WIDTH-1], in_data};
        w_rc      = (shift == 5'd0) ? '0 : (EXT_W'(1) << (shift - 5'd1));
        w_sum     = w_ext + w_rc;
        w_shr     = w_sum >>> shift;
        w_is_sat  = 1'b0;
        w_sat_val = w_shr[IO_DATA_WIDTH-1:0];
        if (w_shr > C_SAT_MAX) begin
            w_sat_val = C_OUT_MAX;
            w_is_sat  = 1'b1;
        end else if (w_shr < C_SAT_MIN) begin
            w_sat_val = C_OUT_MIN;
            w_is_sat  = 1'b1;
        end
`ifdef OUTPUT_RELU_EN
        w_res = w_sat_val[IO_DATA_WIDTH-1] ? '0 : w_sat_val;
`else
        w_res = w_sat_val;
`endif
    end

    // Credit-based readiness from registered state only; S1 always has a
    // reserved FIFO slot, so its write never needs a space check.
    always_comb begin
        w_occ       = {1'b0, r_count} + {{CNT_W{1'b0}}, r_s1_valid};
        in_ready    = (w_occ < C_DEPTH);
        w_not_empty = (r_count != '0);
        w_accept    = in_valid && in_ready && !clear;
        w_push      = r_s1_valid && !clear;
        w_pop       = w_not_empty && out_ready && !clear;
    end

    // Stage 1 register: captures the requantized result on accept
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_x     <= '0;
            r_s1_y     <= '0;
            r_s1_ch    <= '0;
        end else if (clear) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_data <= w_res;
                r_s1_x    <= in_x;
                r_s1_y    <= in_y;
                r_s1_ch   <= in_ch;
            end
        end
    end

    // FIFO storage: written from S1, contents qualified by the count
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {r_s1_data, r_s1_x, r_s1_y, r_s1_ch};
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Sticky saturation and dropped-sample flags
    always_ff @(posedge clk or posedge arst_in) begin
        if (arst_in) begin
            r_sat_flag <= 1'b0;
            r_overflow <= 1'b0;
        end else if (clear) begin
            r_sat_flag <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept && w_is_sat) begin
                r_sat_flag <= 1'b1;
            end
            if (in_valid && !in_ready) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // Output fields come from the FIFO head, forced to zero while empty so
    // that an asynchronous reset clears them without touching storage.
    always_comb begin
        w_head       = r_mem[r_rd_ptr];
        out_valid    = w_not_empty;
        out_data     = w_not_empty ? w_head[ENTRY_W-1 -: IO_DATA_WIDTH] : '0;
        out_x        = w_not_empty ? w_head[Y_W+CH_W +: X_W] : '0;
        out_y        = w_not_empty ? w_head[CH_W +: Y_W] : '0;
        out_ch       = w_not_empty ? w_head[0 +: CH_W] : '0;
        sat_flag     = r_sat_flag;
        overflow_err = r_overflow;
    end

endmodule
`default_nettype wire

// File: tb/tb_output_requantizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_output_requantizer
// Purpose  : Directed self-checking bench for output_requantizer. Inputs
//            change and outputs are sampled on the falling clock edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_output_requantizer;

    localparam int X_W  = 10;
    localparam int Y_W  = 10;
    localparam int CH_W = 6;

    logic              clk = 1'b0;
    logic              arst_in;
    logic              clear;
    logic [4:0]        shift;
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       in_data;
    logic [X_W-1:0]    in_x;
    logic [Y_W-1:0]    in_y;
    logic [CH_W-1:0]   in_ch;
    logic              out_valid;
    logic              out_ready;
    logic [15:0]       out_data;
    logic [X_W-1:0]    out_x;
    logic [Y_W-1:0]    out_y;
    logic [CH_W-1:0]   out_ch;
    logic              sat_flag;
    logic              overflow_err;

    int errors = 0;
    int checks = 0;

    output_requantizer dut (
        .clk          (clk),
        .arst_in      (arst_in),
        .clear        (clear),
        .shift        (shift),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_x         (in_x),
        .in_y         (in_y),
        .in_ch        (in_ch),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_x        (out_x),
        .out_y        (out_y),
        .out_ch       (out_ch),
        .sat_flag     (sat_flag),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    // Drive one sample for a single clock, returning at the next falling edge
    task automatic push_sample(input logic [31:0] d, input int x, input int y, input int ch);
        in_valid = 1'b1;
        in_data  = d;
        in_x     = X_W'(x);
        in_y     = Y_W'(y);
        in_ch    = CH_W'(ch);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Accept the FIFO head for a single clock
    task automatic pop_one();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        arst_in = 1'b1; clear = 1'b0; shift = 5'd0; in_valid = 1'b0;
        in_data = '0; in_x = '0; in_y = '0; in_ch = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        arst_in = 1'b0;
        @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'd0) begin errors++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        checks++; if (sat_flag !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL reset_flags: got sat=%b ovf=%b expected 0 0", sat_flag, overflow_err); end
    endtask

    task automatic test_rounding();
        shift = 5'd8;
        push_sample(32'h0000_1280, 5, 7, 3);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_latency1: got out_valid=%b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL round_latency2: got out_valid=%b expected 1", out_valid); end
        checks++; if (out_data !== 16'd19) begin errors++; $display("FAIL round_data: got %0d expected 19", $signed(out_data)); end
        checks++; if (out_x !== 10'd5 || out_y !== 10'd7 || out_ch !== 6'd3) begin errors++; $display("FAIL round_coords: got %0d/%0d/%0d expected 5/7/3", out_x, out_y, out_ch); end
        pop_one();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL round_pop: got out_valid=%b expected 0", out_valid); end
    endtask

    task automatic test_shift_edges();
        logic [15:0] exp_neg;
        // shift 31 on the largest positive input: needs the extra bit to avoid wrap
        shift = 5'd31;
        push_sample(32'h7FFF_FFFF, 1, 2, 3);
        @(negedge clk);
        checks++; if (out_data !== 16'd1) begin errors++; $display("FAIL shift31_data: got %0d expected 1", $signed(out_data)); end
        pop_one();
        // -40 / 16 = -2.5, half rounds toward +inf
        shift = 5'd4;
`ifdef OUTPUT_RELU_EN
        exp_neg = 16'd0;
`else
        exp_neg = 16'hFFFE;
`endif
        push_sample(32'hFFFF_FFD8, 4, 5, 6);
        @(negedge clk);
        checks++; if (out_data !== exp_neg) begin errors++; $display("FAIL neg_round_data: got %0d expected %0d", $signed(out_data), $signed(exp_neg)); end
        pop_one();
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL no_sat_flag: got %b expected 0", sat_flag); end
    endtask

    task automatic test_saturation();
        logic [15:0] exp_min;
`ifdef OUTPUT_RELU_EN
        exp_min = 16'd0;
`else
        exp_min = 16'h8000;
`endif
        shift = 5'd0;
        push_sample(32'd100000, 8, 9, 10);
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_pos: got %b expected 1", sat_flag); end
        @(negedge clk);
        checks++; if (out_data !== 16'h7FFF) begin errors++; $display("FAIL sat_pos_data: got %0d expected 32767", $signed(out_data)); end
        pop_one();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        checks++; if (sat_flag !== 1'b0) begin errors++; $display("FAIL sat_flag_clear: got %b expected 0", sat_flag); end
        push_sample(-32'sd100000, 11, 12, 13);
        @(negedge clk);
        checks++; if (out_data !== exp_min) begin errors++; $display("FAIL sat_neg_data: got %0d expected %0d", $signed(out_data), $signed(exp_min)); end
        checks++; if (sat_flag !== 1'b1) begin errors++; $display("FAIL sat_flag_neg: got %b expected 1", sat_flag); end
        pop_one();
    endtask

    task automatic test_full();
        shift = 5'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++; if (in_ready !== (i < 4)) begin errors++; $display("FAIL full_in_ready[%0d]: got %b expected %b", i, in_ready, (i < 4)); end
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            in_x     = X_W'(i);
            in_y     = Y_W'(10 + i);
            in_ch    = CH_W'(i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL full_overflow: got %b expected 1", overflow_err); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL full_in_ready_hold: got %b expected 0", in_ready); end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== 16'(100 + i)) begin errors++; $display("FAIL drain_data[%0d]: got v=%b d=%0d expected v=1 d=%0d", i, out_valid, out_data, 100 + i); end
            checks++; if (out_x !== X_W'(i) || out_y !== Y_W'(10 + i) || out_ch !== CH_W'(i)) begin errors++; $display("FAIL drain_coords[%0d]: got %0d/%0d/%0d expected %0d/%0d/%0d", i, out_x, out_y, out_ch, i, 10 + i, i); end
            if (i == 1) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL full_in_ready_return: got %b expected 1", in_ready); end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        shift = 5'd2;
        out_ready = 1'b1;
        for (int t = 0; t < 18; t++) begin
            if (t >= 2) begin
                checks++; if (out_valid !== 1'b1 || out_data !== 16'(2 * (t - 2) + 1) || out_x !== X_W'(t - 2)) begin errors++; $display("FAIL stream[%0d]: got v=%b d=%0d x=%0d expected v=1 d=%0d x=%0d", t - 2, out_valid, out_data, out_x, 2 * (t - 2) + 1, t - 2); end
            end else begin
                checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_early[%0d]: got v=%b expected 0", t, out_valid); end
            end
            if (t < 16) begin
                checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready[%0d]: got %b expected 1", t, in_ready); end
            end
            in_valid = (t < 16);
            in_data  = 32'(t * 8 + 2);
            in_x     = X_W'(t);
            in_y     = Y_W'(t);
            in_ch    = CH_W'(t);
            @(negedge clk);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stream_end: got v=%b expected 0", out_valid); end
    endtask

    task automatic test_clear();
        shift = 5'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 32'd100000 : 32'(20 + i);
            in_x     = X_W'(i + 1);
            in_y     = '0;
            in_ch    = '0;
            @(negedge clk);
        end
        checks++; if (sat_flag !== 1'b1 || overflow_err !== 1'b1) begin errors++; $display("FAIL clear_pre_flags: got sat=%b ovf=%b expected 1 1", sat_flag, overflow_err); end
        clear   = 1'b1;
        in_data = 32'd55;
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_out_valid: got %b expected 0", out_valid); end
        checks++; if (sat_flag !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL clear_flags: got sat=%b ovf=%b expected 0 0", sat_flag, overflow_err); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL clear_in_ready: got %b expected 1", in_ready); end
        repeat (2) @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL clear_discard: got %b expected 0", out_valid); end
    endtask

    task automatic test_async_reset();
        shift = 5'd0;
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 0) ? 32'd100000 : 32'd7;
            in_x     = X_W'(4 + i);
            in_y     = Y_W'(4 + i);
            in_ch    = CH_W'(4 + i);
            @(negedge clk);
        end
        in_valid = 1'b0;
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_x !== 10'd4) begin errors++; $display("FAIL arst_pre: got v=%b x=%0d expected v=1 x=4", out_valid, out_x); end
        #2 arst_in = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_out_valid: got %b expected 0", out_valid); end
        checks++; if (out_data !== 16'd0 || out_x !== '0 || out_y !== '0 || out_ch !== '0) begin errors++; $display("FAIL arst_outputs: got d=%0d x=%0d y=%0d ch=%0d expected all 0", out_data, out_x, out_y, out_ch); end
        checks++; if (in_ready !== 1'b1 || sat_flag !== 1'b0 || overflow_err !== 1'b0) begin errors++; $display("FAIL arst_status: got rdy=%b sat=%b ovf=%b expected 1 0 0", in_ready, sat_flag, overflow_err); end
        #1 arst_in = 1'b0;
        @(negedge clk);
        push_sample(32'd40, 9, 8, 7);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL arst_latency1: got %b expected 0", out_valid); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b1 || out_data !== 16'd40 || out_x !== 10'd9) begin errors++; $display("FAIL arst_latency2: got v=%b d=%0d x=%0d expected v=1 d=40 x=9", out_valid, out_data, out_x); end
        pop_one();
    endtask

    initial begin
        test_reset();
        test_rounding();
        test_shift_edges();
        test_saturation();
        test_full();
        test_back_to_back();
        test_clear();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Runaway guard
    initial begin
        #200000;
        $display("FAIL timeout: got no completion expected finish before 200000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
